// File: rtl/fetch_buffer_pkg.sv
// Shared definitions for the fetch buffer and the fetch address check:
// exception codes, default legal fetch window and the buffered entry layout.
package fetch_buffer_pkg;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  localparam logic [31:0] PC_BASE_DEF  = 32'h0000_3000;
  localparam logic [31:0] PC_LIMIT_DEF = 32'h0000_6FFC;

  // One buffered fetch: 32 + 32 + 5 + 1 = 70 bits.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  excode;
    logic        bd;
  } fb_entry_t;

endpackage

// File: rtl/fetch_addr_check.sv
// Combinational fetch address legality check. Flags AdEL for a misaligned
// address or one outside [PC_BASE, PC_LIMIT]. Also used by the exception unit.
module fetch_addr_check
  import fetch_buffer_pkg::*;
#(
  parameter logic [31:0] PC_BASE  = PC_BASE_DEF,
  parameter logic [31:0] PC_LIMIT = PC_LIMIT_DEF
) (
  input  logic [31:0] pc,
  output logic [4:0]  excode
);

  // Misaligned or out-of-window fetches raise an address error on load.
  always_comb begin
    excode = EXC_NONE;
    if ((pc[1:0] != 2'b00) || (pc < PC_BASE) || (pc > PC_LIMIT)) begin
      excode = EXC_ADEL;
    end
  end

endmodule

// File: rtl/fetch_buffer.sv
// In-order instruction buffer between fetch and decode.
// Optional build macro FETCH_BUFFER_BYPASS_EN: when defined, a legal fetch
// arriving at an empty buffer is shown to decode in the same cycle and is
// consumed without storage if decode is ready. When undefined, every entry
// spends at least one cycle in storage and f_* never reaches d_* directly.
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] PC_BASE  = PC_BASE_DEF,
  parameter logic [31:0] PC_LIMIT = PC_LIMIT_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     f_valid,
  input  logic [31:0]              f_pc,
  input  logic [31:0]              f_instr,
  input  logic                     f_bd,
  output logic                     f_ready,
  output logic                     d_valid,
  input  logic                     d_ready,
  output logic [31:0]              d_pc,
  output logic [31:0]              d_instr,
  output logic [4:0]               d_excode,
  output logic                     d_bd,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  fb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic [4:0] f_excode;
  fb_entry_t  in_entry;
  fb_entry_t  out_entry;
  logic       stored_valid;
  logic       bypass;
  logic       push;
  logic       pop;
  logic       store;
  logic       take;

  fetch_addr_check #(
    .PC_BASE  (PC_BASE),
    .PC_LIMIT (PC_LIMIT)
  ) u_addr_check (
    .pc     (f_pc),
    .excode (f_excode)
  );

  // Tag the incoming fetch; a faulting fetch stores a zero instruction word.
  always_comb begin
    in_entry.pc     = f_pc;
    in_entry.instr  = (f_excode != EXC_NONE) ? 32'h0 : f_instr;
    in_entry.excode = f_excode;
    in_entry.bd     = f_bd;
  end

  // Handshakes, bypass selection and push/pop qualification.
  always_comb begin
    stored_valid = (count != '0);
    f_ready      = (count != CNT_W'(DEPTH));
`ifdef FETCH_BUFFER_BYPASS_EN
    bypass       = ~stored_valid & f_valid & (f_excode == EXC_NONE) & ~flush;
    out_entry    = bypass ? in_entry : mem[rd_ptr];
`else
    bypass       = 1'b0;
    out_entry    = mem[rd_ptr];
`endif
    d_valid      = stored_valid | bypass;
    push         = f_valid & f_ready & ~flush;
    pop          = d_valid & d_ready & ~flush;
    // A bypassed entry taken by decode this cycle never enters storage.
    store        = push & ~(bypass & d_ready);
    take         = pop & ~bypass;
  end

  // Decode-side view: head entry, or fixed idle values while empty.
  always_comb begin
    if (d_valid) begin
      d_pc     = out_entry.pc;
      d_instr  = out_entry.instr;
      d_excode = out_entry.excode;
      d_bd     = out_entry.bd;
    end else begin
      d_pc     = PC_BASE;
      d_instr  = 32'h0;
      d_excode = EXC_NONE;
      d_bd     = 1'b0;
    end
  end

  // Pointer and occupancy control; reset outranks flush outranks push/pop.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (store) wr_ptr <= wr_ptr + 1'b1;
      if (take)  rd_ptr <= rd_ptr + 1'b1;
      case ({store, take})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are written once at push and never touched again.
  always_ff @(posedge clk) begin
    if (store && !reset && !flush) begin
      mem[wr_ptr] <= in_entry;
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: directed scenarios plus randomized
// traffic, all checked against a queue-based reference model.
module tb_fetch_buffer;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] PC_BASE  = 32'h0000_3000;
  localparam logic [31:0] PC_LIMIT = 32'h0000_6FFC;

  logic        clk = 1'b0;
  logic        reset, flush, f_valid, f_bd, d_ready;
  logic [31:0] f_pc, f_instr;
  logic        f_ready, d_valid, d_bd;
  logic [31:0] d_pc, d_instr;
  logic [4:0]  d_excode;
  logic [$clog2(DEPTH):0] count;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  exc;
    logic        bd;
  } ment_t;

  ment_t q[$];
  bit    model_ok = 1'b0;

  fetch_buffer #(
    .DEPTH    (DEPTH),
    .PC_BASE  (PC_BASE),
    .PC_LIMIT (PC_LIMIT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .f_valid  (f_valid),
    .f_pc     (f_pc),
    .f_instr  (f_instr),
    .f_bd     (f_bd),
    .f_ready  (f_ready),
    .d_valid  (d_valid),
    .d_ready  (d_ready),
    .d_pc     (d_pc),
    .d_instr  (d_instr),
    .d_excode (d_excode),
    .d_bd     (d_bd),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit pc_bad(input logic [31:0] pc);
    return (pc % 4 != 0) || (pc < PC_BASE) || (pc > PC_LIMIT);
  endfunction

  function automatic bit model_bypass();
`ifdef FETCH_BUFFER_BYPASS_EN
    return (q.size() == 0) && f_valid && !pc_bad(f_pc) && !flush;
`else
    return 1'b0;
`endif
  endfunction

  // Compare every output against the model view of the current cycle.
  task automatic compare_all();
    ment_t e;
    bit    byp, vld;
    byp = model_bypass();
    vld = byp || (q.size() != 0);
    if (byp) begin
      e.pc = f_pc; e.instr = f_instr; e.exc = 5'd0; e.bd = f_bd;
    end else if (q.size() != 0) begin
      e = q[0];
    end else begin
      e.pc = PC_BASE; e.instr = 32'h0; e.exc = 5'd0; e.bd = 1'b0;
    end
    chk("d_valid",  {31'h0, d_valid}, {31'h0, vld});
    chk("f_ready",  {31'h0, f_ready}, {31'h0, (q.size() != DEPTH)});
    chk("count",    32'(count), 32'(q.size()));
    chk("d_pc",     d_pc, e.pc);
    chk("d_instr",  d_instr, e.instr);
    chk("d_excode", {27'h0, d_excode}, {27'h0, e.exc});
    chk("d_bd",     {31'h0, d_bd}, {31'h0, e.bd});
  endtask

  // Advance the model across one clock edge using the held inputs.
  task automatic model_edge();
    ment_t e;
    bit    byp, vld, psh, pp;
    if (reset || flush) begin
      q.delete();
      if (reset) model_ok = 1'b1;
      return;
    end
    byp = model_bypass();
    vld = byp || (q.size() != 0);
    psh = f_valid && (q.size() != DEPTH);
    pp  = vld && d_ready;
    if (pp && byp) return;
    if (pp) void'(q.pop_front());
    if (psh) begin
      e.pc    = f_pc;
      e.exc   = pc_bad(f_pc) ? 5'd4 : 5'd0;
      e.instr = pc_bad(f_pc) ? 32'h0 : f_instr;
      e.bd    = f_bd;
      q.push_back(e);
    end
  endtask

  task automatic cyc(input logic rs, input logic fl, input logic fv, input logic [31:0] pc,
                     input logic [31:0] ins, input logic bd, input logic dr);
    reset = rs; flush = fl; f_valid = fv; f_pc = pc; f_instr = ins; f_bd = bd; d_ready = dr;
    @(negedge clk);
    if (model_ok) compare_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Park inputs idle and let outputs settle for directed constant checks.
  task automatic peek();
    reset = 1'b0; flush = 1'b0; f_valid = 1'b0; d_ready = 1'b0; f_bd = 1'b0;
    #1;
  endtask

  logic [31:0] adel_pc  [4] = '{32'h3002, 32'h2FFC, 32'h6FFC, 32'h7000};
  logic [4:0]  adel_exc [4] = '{5'd4, 5'd4, 5'd0, 5'd4};
  logic [31:0] odd_pc   [7] = '{32'h2FFC, 32'h7000, 32'h3001, 32'h6FFC, 32'h3000, 32'h0, 32'hFFFF_FFFC};

  initial begin
    reset = 1'b1; flush = 1'b0; f_valid = 1'b0; f_pc = '0; f_instr = '0; f_bd = 1'b0; d_ready = 1'b0;

    // Reset then idle
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    peek();
    chk("rst_d_valid", {31'h0, d_valid}, 32'h0);
    chk("rst_f_ready", {31'h0, f_ready}, 32'h1);
    chk("rst_count",   32'(count), 32'h0);
    chk("rst_d_pc",    d_pc, 32'h3000);
    chk("rst_d_instr", d_instr, 32'h0);

    // Two pushes while decode stalls, then drain
    cyc(0, 0, 1, 32'h3000, 32'h2401_0001, 0, 0);
    cyc(0, 0, 1, 32'h3004, 32'h2402_0002, 0, 0);
    peek();
    chk("full_count",   32'(count), 32'h2);
    chk("full_f_ready", {31'h0, f_ready}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 0);
      peek();
      chk("hold_d_pc", d_pc, 32'h3000);
    end
    cyc(0, 0, 0, 0, 0, 0, 1);
    peek();
    chk("drain_d_pc", d_pc, 32'h3004);
    cyc(0, 0, 0, 0, 0, 0, 1);
    peek();
    chk("drain_empty", {31'h0, d_valid}, 32'h0);

    // Continuous streaming with pointer wrap
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 1, 32'h3000 + 32'(i * 4), 32'h1000 + 32'(i), 0, 1);
      peek();
      chk("stream_cnt_le1", {31'h0, (count <= 1)}, 32'h1);
    end
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);

    // Address error tagging at the window edges
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 1, adel_pc[i], 32'hDEAD_0000 + 32'(i), 0, 0);
      peek();
      chk("adel_excode", {27'h0, d_excode}, {27'h0, adel_exc[i]});
      chk("adel_pc", d_pc, adel_pc[i]);
      if (i == 0) chk("adel_instr0", d_instr, 32'h0);
      cyc(0, 0, 0, 0, 0, 0, 1);
    end

    // Flush with a full buffer and an incoming entry
    cyc(0, 0, 1, 32'h3000, 32'hA, 0, 0);
    cyc(0, 0, 1, 32'h3004, 32'hB, 0, 0);
    cyc(0, 1, 1, 32'h3008, 32'hC, 0, 0);
    peek();
    chk("flush_count",   32'(count), 32'h0);
    chk("flush_d_valid", {31'h0, d_valid}, 32'h0);
    cyc(0, 0, 1, 32'h300C, 32'hD, 0, 0);
    peek();
    chk("flush_next_pc", d_pc, 32'h300C);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 1, 32'h3000, 32'hE, 0, 0);
    cyc(1, 1, 1, 32'h3004, 32'hF, 0, 0);
    peek();
    chk("rstflush_count",   32'(count), 32'h0);
    chk("rstflush_f_ready", {31'h0, f_ready}, 32'h1);

    // Delay-slot flag carried through
    cyc(0, 0, 1, 32'h3010, 32'h1234, 1, 0);
    peek();
    chk("bd_flag", {31'h0, d_bd}, 32'h1);
    cyc(0, 0, 0, 0, 0, 0, 1);

    // Same-cycle visibility only with bypass built in
    reset = 0; flush = 0; f_valid = 1; f_pc = 32'h3020; f_instr = 32'h55; f_bd = 0; d_ready = 1;
    #1;
`ifdef FETCH_BUFFER_BYPASS_EN
    chk("byp_d_valid", {31'h0, d_valid}, 32'h1);
    chk("byp_d_pc",    d_pc, 32'h3020);
`else
    chk("nobyp_d_valid", {31'h0, d_valid}, 32'h0);
    chk("nobyp_d_pc",    d_pc, 32'h3000);
`endif
    cyc(0, 0, 1, 32'h3020, 32'h55, 0, 1);
    peek();
`ifdef FETCH_BUFFER_BYPASS_EN
    chk("byp_count", 32'(count), 32'h0);
`else
    chk("nobyp_count", 32'(count), 32'h1);
`endif
    cyc(0, 0, 0, 0, 0, 0, 1);

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      logic [31:0] pc;
      if ($urandom_range(0, 6) == 0) pc = odd_pc[$urandom_range(0, 6)];
      else pc = PC_BASE + ($urandom_range(0, 32'hFFF) << 2);
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 24) == 0),
          ($urandom_range(0, 2) != 0), pc, $urandom, ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 2) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
